// File: rtl/nes_pad_reader.sv
// NES/4021 controller poller: periodically latches and shifts out the 8 pad
// buttons and presents them, active high, as a stable byte with update pulses.
module nes_pad_reader #(
    parameter int CLK_DIV       = 384,
    parameter int POLL_INTERVAL = 1066666
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       nes_data_i,
    output logic       nes_latch_o,
    output logic       nes_clk_o,
    output logic [7:0] buttons_o,
    output logic       valid_o,
    output logic       changed_o,
    output logic       busy_o
);

    localparam int PH_W    = $clog2(2 * CLK_DIV);
    localparam int TM_W    = (POLL_INTERVAL < 1) ? 1 : $clog2(POLL_INTERVAL + 1);
    localparam int TM_LAST = (POLL_INTERVAL > 0) ? POLL_INTERVAL - 1 : 0;
    localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0] DIV_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [TM_W-1:0] TIMER_LAST = TM_W'(TM_LAST);
    localparam logic            AUTO_POLL  = (POLL_INTERVAL != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETTLE,
        S_CLK_HI,
        S_CLK_LO,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PH_W-1:0]   phase;
    logic [2:0]        bit_idx;
    logic [TM_W-1:0]   timer;
    logic [1:0]        sync;
    logic [7:0]        shift_reg;
    logic              phase_end;
    logic              sample;
    logic              data_s;

    assign data_s = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        phase_end   = 1'b0;
        sample      = 1'b0;
        nes_latch_o = 1'b0;
        nes_clk_o   = 1'b0;
        busy_o      = 1'b1;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                // a start request and timer expiry together still make one poll
                if (start_i || (AUTO_POLL && (timer == TIMER_LAST))) begin
                    state_next = S_LATCH;
                end
            end
            S_LATCH: begin
                nes_latch_o = 1'b1;
                phase_end   = (phase == LATCH_LAST);
                if (phase_end) state_next = S_SETTLE;
            end
            S_SETTLE: begin
                phase_end = (phase == DIV_LAST);
                sample    = phase_end;
                if (phase_end) state_next = S_CLK_HI;
            end
            S_CLK_HI: begin
                nes_clk_o = 1'b1;
                phase_end = (phase == DIV_LAST);
                if (phase_end) state_next = S_CLK_LO;
            end
            S_CLK_LO: begin
                phase_end = (phase == DIV_LAST);
                sample    = phase_end;
                if (phase_end) state_next = (bit_idx == 3'd7) ? S_DONE : S_CLK_HI;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= '0;
            bit_idx   <= '0;
            timer     <= '0;
            sync      <= '1;
            shift_reg <= '0;
            buttons_o <= '0;
            valid_o   <= 1'b0;
            changed_o <= 1'b0;
        end else begin
            sync      <= {sync[0], nes_data_i};
            valid_o   <= 1'b0;
            changed_o <= 1'b0;

            if (state == S_IDLE && state_next == S_IDLE) begin
                timer <= timer + TM_W'(1);
            end else begin
                timer <= '0;
            end

            if (state == S_IDLE || state == S_DONE || phase_end) begin
                phase <= '0;
            end else begin
                phase <= phase + PH_W'(1);
            end

            // pad sends A first; shifting right lands bit i at position i after 8 samples
            if (sample) begin
                shift_reg <= {data_s, shift_reg[7:1]};
            end

            if (state == S_SETTLE && phase_end) begin
                bit_idx <= 3'd1;
            end else if (state == S_CLK_LO && phase_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (state == S_DONE) begin
                buttons_o <= ~shift_reg;
                valid_o   <= 1'b1;
                changed_o <= (~shift_reg != buttons_o);
            end
        end
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: two instances (manual poll and auto poll) each
// driven by a behavioural 4021 pad; expected buttons are the inverted pad byte.
module tb_nes_pad_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] pad0, pad1;
    logic       latch0, nclk0, valid0, changed0, busy0;
    logic       latch1, nclk1, valid1, changed1, busy1;
    logic [7:0] buttons0, buttons1;
    logic [7:0] sr0 = 8'hFF, sr1 = 8'hFF;
    logic       prev0 = 1'b0, prev1 = 1'b0;
    logic       data0, data1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_buttons0;

    always #5 clk = ~clk;

    nes_pad_reader #(.CLK_DIV(4), .POLL_INTERVAL(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .nes_data_i(data0),
        .nes_latch_o(latch0), .nes_clk_o(nclk0), .buttons_o(buttons0),
        .valid_o(valid0), .changed_o(changed0), .busy_o(busy0)
    );

    nes_pad_reader #(.CLK_DIV(4), .POLL_INTERVAL(10)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .nes_data_i(data1),
        .nes_latch_o(latch1), .nes_clk_o(nclk1), .buttons_o(buttons1),
        .valid_o(valid1), .changed_o(changed1), .busy_o(busy1)
    );

    // 4021 pad: parallel load while latch is high, shift toward Q8 on each clock rise
    always @(posedge clk) begin
        prev0 <= nclk0;
        if (latch0) sr0 <= pad0;
        else if (nclk0 && !prev0) sr0 <= {1'b1, sr0[7:1]};
        prev1 <= nclk1;
        if (latch1) sr1 <= pad1;
        else if (nclk1 && !prev1) sr1 <= {1'b1, sr1[7:1]};
    end
    assign data0 = sr0[0];
    assign data1 = sr1[0];

    task automatic do_poll(input logic [7:0] pad, output int lat, output int rises,
                           output int t_valid, output int overlap);
        logic pc;
        pad0 = pad;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        lat = 0; rises = 0; overlap = 0; t_valid = -1; pc = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (valid0) begin
                t_valid = t;
                break;
            end
            if (latch0) lat++;
            if (latch0 && nclk0) overlap++;
            if (nclk0 && !pc) rises++;
            pc = nclk0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; pad0 = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_buttons0 = 8'h00;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks++;
            if ({latch0, nclk0, busy0, valid0} !== 4'b0000 || buttons0 !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: latch=%b clk=%b busy=%b valid=%b buttons=%h required all 0",
                         i, latch0, nclk0, busy0, valid0, buttons0);
            end
        end
    endtask

    task automatic test_first_poll();
        int lat, rises, tv, ov;
        do_poll(8'hF6, lat, rises, tv, ov);
        n_checks++;
        if (tv !== 69) begin n_fail++; $display("FAIL poll_latency: got %0d required 69", tv); end
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("FAIL latch_cycles: got %0d required 8", lat); end
        n_checks++;
        if (rises !== 7) begin n_fail++; $display("FAIL clk_rises: got %0d required 7", rises); end
        n_checks++;
        if (ov !== 0) begin n_fail++; $display("FAIL latch_clk_overlap: got %0d required 0", ov); end
        n_checks++;
        if (buttons0 !== 8'h09) begin n_fail++; $display("FAIL first_buttons: got %h required 09", buttons0); end
        n_checks++;
        if (changed0 !== 1'b1) begin n_fail++; $display("FAIL first_changed: got %b required 1", changed0); end
        exp_buttons0 = 8'h09;
        @(negedge clk);
        n_checks++;
        if (valid0 !== 1'b0 || changed0 !== 1'b0) begin
            n_fail++; $display("FAIL pulse_width: valid=%b changed=%b required 0 0", valid0, changed0);
        end
    endtask

    task automatic test_same_state();
        int lat, rises, tv, ov;
        do_poll(8'hF6, lat, rises, tv, ov);
        n_checks++;
        if (tv !== 69) begin n_fail++; $display("FAIL repeat_latency: got %0d required 69", tv); end
        n_checks++;
        if (buttons0 !== 8'h09) begin n_fail++; $display("FAIL repeat_buttons: got %h required 09", buttons0); end
        n_checks++;
        if (changed0 !== 1'b0) begin n_fail++; $display("FAIL repeat_changed: got %b required 0", changed0); end
    endtask

    task automatic test_bit_order();
        int lat, rises, tv, ov;
        logic [7:0] one_hot;
        do_poll(8'h6F, lat, rises, tv, ov);
        n_checks++;
        if (buttons0 !== 8'h90) begin n_fail++; $display("FAIL right_up: got %h required 90", buttons0); end
        n_checks++;
        if (changed0 !== 1'b1) begin n_fail++; $display("FAIL right_up_changed: got %b required 1", changed0); end
        exp_buttons0 = 8'h90;
        for (int i = 0; i < 8; i++) begin
            one_hot = 8'h01 << i;
            do_poll(~one_hot, lat, rises, tv, ov);
            n_checks++;
            if (tv !== 69 || buttons0 !== one_hot) begin
                n_fail++;
                $display("FAIL single_button_%0d: got %h at t=%0d required %h at t=69", i, buttons0, tv, one_hot);
            end
            exp_buttons0 = one_hot;
        end
    endtask

    task automatic test_random();
        int lat, rises, tv, ov;
        logic [7:0] pad;
        logic [7:0] want;
        for (int i = 0; i < 8; i++) begin
            pad = (i == 4) ? ~exp_buttons0 : 8'($urandom);
            want = ~pad;
            do_poll(pad, lat, rises, tv, ov);
            n_checks++;
            if (buttons0 !== want || changed0 !== (want != exp_buttons0)) begin
                n_fail++;
                $display("FAIL random_%0d: got buttons=%h changed=%b required buttons=%h changed=%b",
                         i, buttons0, changed0, want, (want != exp_buttons0));
            end
            exp_buttons0 = want;
        end
    endtask

    task automatic test_reset_mid_poll();
        int lat, rises, tv, ov, stray;
        pad0 = 8'h5A;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (29) @(negedge clk);
        n_checks++;
        if (nclk0 !== 1'b1 || busy0 !== 1'b1) begin
            n_fail++; $display("FAIL bit3_clk_hi: clk=%b busy=%b required 1 1", nclk0, busy0);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({latch0, nclk0, busy0, valid0} !== 4'b0000 || buttons0 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_abort: latch=%b clk=%b busy=%b valid=%b buttons=%h required all 0",
                     latch0, nclk0, busy0, valid0, buttons0);
        end
        rst = 1'b0;
        exp_buttons0 = 8'h00;
        stray = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (valid0 || busy0) stray++;
        end
        n_checks++;
        if (stray !== 0) begin n_fail++; $display("FAIL post_reset_quiet: got %0d active cycles required 0", stray); end
        do_poll(8'h3C, lat, rises, tv, ov);
        n_checks++;
        if (tv !== 69 || rises !== 7 || buttons0 !== 8'hC3 || changed0 !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_poll: t=%0d rises=%0d buttons=%h changed=%b required 69 7 c3 1",
                     tv, rises, buttons0, changed0);
        end
        exp_buttons0 = 8'hC3;
    endtask

    task automatic test_start_while_busy();
        int tv, extra;
        pad0 = 8'hE7;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (20) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        tv = -1;
        for (int t = 21; t < 200; t++) begin
            if (valid0) begin tv = t; break; end
            @(negedge clk);
        end
        n_checks++;
        if (tv !== 69 || buttons0 !== 8'h18) begin
            n_fail++; $display("FAIL busy_start_poll: t=%0d buttons=%h required 69 18", tv, buttons0);
        end
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid0 || busy0) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL busy_start_dropped: got %0d active cycles required 0", extra); end
    endtask

    task automatic test_auto_poll();
        int found, n;
        found = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (valid1) begin found = 1; break; end
        end
        n_checks++;
        if (found !== 1) begin n_fail++; $display("FAIL auto_first_valid: timeout, got none required a pulse"); end
        for (int p = 0; p < 3; p++) begin
            n = -1;
            for (int t = 1; t <= 200; t++) begin
                @(negedge clk);
                start1 = (p == 0 && t == 30) || (p == 1 && t == 9);
                if (p == 0 && t == 30) begin
                    n_checks++;
                    if (busy1 !== 1'b1) begin n_fail++; $display("FAIL auto_busy: got %b required 1", busy1); end
                end
                if (valid1) begin n = t; break; end
            end
            start1 = 1'b0;
            n_checks++;
            if (n !== 79) begin n_fail++; $display("FAIL auto_period_%0d: got %0d required 79", p, n); end
            n_checks++;
            if (buttons1 !== ~pad1) begin n_fail++; $display("FAIL auto_buttons_%0d: got %h required %h", p, buttons1, ~pad1); end
        end
    endtask

    initial begin
        pad1 = 8'($urandom);
        test_reset();
        test_first_poll();
        test_same_state();
        test_bit_order();
        test_random();
        test_reset_mid_poll();
        test_start_while_busy();
        test_auto_poll();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
